// File: rtl/riscv_pkg.sv
// riscv_pkg: instruction classes, RV32I opcode constants and encoder helpers
package riscv_pkg;
  typedef enum logic [2:0] {
    CLS_LW    = 3'd0,
    CLS_SW    = 3'd1,
    CLS_RTYPE = 3'd2,
    CLS_BEQ   = 3'd3,
    CLS_IALU  = 3'd4,
    CLS_JAL   = 3'd5
  } instr_class_t;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [2:0] F3_WORD   = 3'b010;
  localparam logic [2:0] F3_BEQ    = 3'b000;
  localparam logic [31:0] NOP      = 32'h00000013;
  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } enc_entry_t;
  function automatic logic in_range(input logic [31:0] v, input int lo, input int hi);
    return $signed(v) >= lo && $signed(v) <= hi;
  endfunction
endpackage

// File: rtl/enc_fifo.sv
// enc_fifo: two-entry buffer of encoded words with simultaneous push/pop
module enc_fifo
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  enc_entry_t din,
  output enc_entry_t dout,
  output logic [1:0] count
);
  enc_entry_t mem [2];
  logic wp, rp;
  // storage, pointers and occupancy; reset discards anything buffered
  always_ff @(posedge clk) begin
    if (!reset) begin
      wp     <= 1'b0;
      rp     <= 1'b0;
      count  <= 2'd0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= !wp;
      end
      if (pop) rp <= !rp;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
  assign dout = mem[rp];
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: encodes instruction requests into RV32I words, buffered for the consumer
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_class,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count
);
  logic [31:0] word;
  logic        bad;
  logic        push, pop;
  logic [1:0]  occ;
  enc_entry_t  head;
  // field packing and range checks; anything unrecognised is an error
  always_comb begin
    word = NOP;
    bad  = 1'b1;
    case (in_class)
      CLS_LW: begin
        word = {imm[11:0], rs1, F3_WORD, rd, OP_LOAD};
        bad  = !in_range(imm, -2048, 2047);
      end
      CLS_SW: begin
        word = {imm[11:5], rs2, rs1, F3_WORD, imm[4:0], OP_STORE};
        bad  = !in_range(imm, -2048, 2047);
      end
      CLS_RTYPE: begin
        word = {1'b0, funct7b5, 5'b00000, rs2, rs1, funct3, rd, OP_OP};
        bad  = 1'b0;
      end
      CLS_BEQ: begin
        word = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OP_BRANCH};
        bad  = !in_range(imm, -4096, 4094) || imm[0];
      end
      CLS_IALU: begin
        word = {imm[11:0], rs1, funct3, rd, OP_OPIMM};
        bad  = !in_range(imm, -2048, 2047);
      end
      CLS_JAL: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
        bad  = !in_range(imm, -1048576, 1048574) || imm[0];
      end
      default: ;
    endcase
  end
  assign in_ready  = reset && (occ != 2'd2 || out_ready);
  assign out_valid = occ != 2'd0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_instr = head.instr;
  assign out_err   = head.err;
  enc_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   ('{instr: bad ? NOP : word, err: bad}),
    .dout  (head),
    .count (occ)
  );
  // count of accepted requests, wrapping naturally
  always_ff @(posedge clk) begin
    if (!reset) enc_count <= '0;
    else if (push) enc_count <= enc_count + CNT_W'(1);
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed and randomized checks of instr_encoder against a field-arithmetic model
module tb_instr_encoder;
  logic        clk = 0, reset = 0, in_valid = 0, in_ready, funct7b5 = 0;
  logic [2:0]  in_class = 0, funct3 = 0;
  logic [4:0]  rd = 0, rs1 = 0, rs2 = 0;
  logic [31:0] imm = 0, out_instr;
  logic        out_valid, out_ready = 0, out_err;
  logic [15:0] enc_count;
  int checks = 0, failures = 0, exp_count = 0;
  logic [32:0] q[$];

  always #5 clk = ~clk;

  instr_encoder #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7b5(funct7b5), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err), .enc_count(enc_count)
  );

  function automatic int unsigned fld(input int unsigned u, input int hi, input int lo);
    return (u >> lo) & ((32'd1 << (hi - lo + 1)) - 1);
  endfunction

  function automatic logic [32:0] ref_enc(input int c, input int d, input int a, input int b,
                                          input int f3, input int f7, input logic [31:0] im);
    longint v = longint'($signed(im));
    int unsigned u = im, w = 0;
    logic e = 0;
    case (c)
      0: begin e = v < -2048 || v > 2047; w = (fld(u,11,0) << 20) + (a << 15) + (2 << 12) + (d << 7) + 3; end
      1: begin e = v < -2048 || v > 2047; w = (fld(u,11,5) << 25) + (b << 20) + (a << 15) + (2 << 12) + (fld(u,4,0) << 7) + 35; end
      2: begin w = (f7 << 30) + (b << 20) + (a << 15) + (f3 << 12) + (d << 7) + 51; end
      3: begin e = v < -4096 || v > 4094 || (v % 2) != 0;
         w = (fld(u,12,12) << 31) + (fld(u,10,5) << 25) + (b << 20) + (a << 15) + (fld(u,4,1) << 8) + (fld(u,11,11) << 7) + 99; end
      4: begin e = v < -2048 || v > 2047; w = (fld(u,11,0) << 20) + (a << 15) + (f3 << 12) + (d << 7) + 19; end
      5: begin e = v < -1048576 || v > 1048574 || (v % 2) != 0;
         w = (fld(u,20,20) << 31) + (fld(u,10,1) << 21) + (fld(u,11,11) << 20) + (fld(u,19,12) << 12) + (d << 7) + 111; end
      default: e = 1;
    endcase
    if (e) w = 32'h13;
    return {w[31:0], e};
  endfunction

  task automatic drive(input int c, input int d, input int a, input int b, input int f3,
                       input int f7, input logic [31:0] im);
    in_valid = 1; in_class = 3'(c); rd = 5'(d); rs1 = 5'(a); rs2 = 5'(b);
    funct3 = 3'(f3); funct7b5 = 1'(f7); imm = im;
  endtask

  task automatic test_reset();
    reset = 0; in_valid = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL reset_out_instr got=%h exp=0", out_instr); end
    checks++; if (out_err !== 1'b0) begin failures++; $display("FAIL reset_out_err got=%b exp=0", out_err); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (enc_count !== 16'h0) begin failures++; $display("FAIL reset_enc_count got=%h exp=0", enc_count); end
    reset = 1; exp_count = 0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    int cls[5] = '{0, 2, 1, 3, 5};
    int dd[5]  = '{5, 3, 0, 0, 1};
    int aa[5]  = '{2, 1, 2, 0, 0};
    int bb[5]  = '{0, 2, 6, 0, 0};
    int ff[5]  = '{0, 1, 0, 0, 0};
    int ii[5]  = '{8, 0, 12, 8, 16};
    logic [31:0] ew[5] = '{32'h00812283, 32'h402081B3, 32'h00612623, 32'h00000463, 32'h010000EF};
    out_ready = 1;
    for (int k = 0; k < 5; k++) begin
      drive(cls[k], dd[k], aa[k], bb[k], 0, ff[k], 32'(ii[k]));
      @(posedge clk); #1;
      in_valid = 0; exp_count++;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL vec%0d_valid got=%b exp=1", k, out_valid); end
      checks++; if (out_instr !== ew[k]) begin failures++; $display("FAIL vec%0d_instr got=%h exp=%h", k, out_instr, ew[k]); end
      checks++; if (out_err !== 1'b0) begin failures++; $display("FAIL vec%0d_err got=%b exp=0", k, out_err); end
      @(posedge clk); #1;
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL vec_drained got=%b exp=0", out_valid); end
    checks++; if (enc_count !== 16'(exp_count)) begin failures++; $display("FAIL vec_count got=%0d exp=%0d", enc_count, exp_count); end
  endtask

  task automatic test_errors();
    int cls[3] = '{3, 4, 6};
    int ii[3]  = '{7, 2048, 0};
    out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      drive(cls[k], 4, 5, 6, 1, 0, 32'(ii[k]));
      @(posedge clk); #1;
      in_valid = 0; exp_count++;
      checks++; if (out_instr !== 32'h13) begin failures++; $display("FAIL err%0d_instr got=%h exp=00000013", k, out_instr); end
      checks++; if (out_err !== 1'b1) begin failures++; $display("FAIL err%0d_flag got=%b exp=1", k, out_err); end
      @(posedge clk); #1;
    end
    checks++; if (enc_count !== 16'(exp_count)) begin failures++; $display("FAIL err_count got=%0d exp=%0d", enc_count, exp_count); end
  endtask

  task automatic test_backpressure();
    logic [32:0] w[3];
    int idx = 0, got = 0;
    logic acc, pp;
    for (int k = 0; k < 3; k++) w[k] = ref_enc(0, 10 + k, 1, 0, 0, 0, 32'(4 * k));
    out_ready = 0;
    drive(0, 10, 1, 0, 0, 0, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin idx++; exp_count++; if (idx < 3) drive(0, 10 + idx, 1, 0, 0, 0, 32'(4 * idx)); else in_valid = 0; end
    end
    @(negedge clk);
    checks++; if (idx !== 2) begin failures++; $display("FAIL bp_accepted got=%0d exp=2", idx); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_instr !== w[0][32:1]) begin failures++; $display("FAIL bp_head got=%h exp=%h", out_instr, w[0][32:1]); end
    @(posedge clk); #1;
    out_ready = 1;
    for (int c = 0; c < 10 && got < 3; c++) begin
      @(negedge clk); acc = in_valid && in_ready; pp = out_valid && out_ready;
      if (pp) begin
        checks++;
        if (got > 2 || {out_instr, out_err} !== w[got]) begin failures++; $display("FAIL bp_order%0d got=%h exp=%h", got, {out_instr, out_err}, w[got % 3]); end
        got++;
      end
      @(posedge clk); #1;
      if (acc) begin idx++; exp_count++; if (idx < 3) drive(0, 10 + idx, 1, 0, 0, 0, 32'(4 * idx)); else in_valid = 0; end
    end
    checks++; if (got !== 3) begin failures++; $display("FAIL bp_drain_count got=%0d exp=3", got); end
    checks++; if (enc_count !== 16'(exp_count)) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", enc_count, exp_count); end
  endtask

  task automatic test_full_passthrough();
    logic [32:0] w[6];
    int idx = 0, got = 0;
    logic acc, pp;
    for (int k = 0; k < 6; k++) w[k] = ref_enc(4, k + 1, k + 2, 0, k % 8, 0, 32'(k * 3 - 5));
    out_ready = 0;
    drive(4, 1, 2, 0, 0, 0, 32'(-5));
    for (int c = 0; c < 6 && idx < 2; c++) begin
      @(negedge clk); acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin idx++; exp_count++; drive(4, idx + 1, idx + 2, 0, idx % 8, 0, 32'(idx * 3 - 5)); end
    end
    out_ready = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); acc = in_valid && in_ready; pp = out_valid && out_ready;
      checks++; if (!(acc && pp)) begin failures++; $display("FAIL full_pushpop%0d got=%b%b exp=11", c, acc, pp); end
      if (pp) begin
        checks++;
        if ({out_instr, out_err} !== w[got]) begin failures++; $display("FAIL full_order%0d got=%h exp=%h", got, {out_instr, out_err}, w[got]); end
        got++;
      end
      @(posedge clk); #1;
      if (acc) begin idx++; exp_count++; if (idx < 6) drive(4, idx + 1, idx + 2, 0, idx % 8, 0, 32'(idx * 3 - 5)); else in_valid = 0; end
    end
    out_ready = 0; in_valid = 0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_still_full got=%b exp=0", in_ready); end
    @(posedge clk); #1;
    out_ready = 1;
    for (int c = 0; c < 6 && got < 6; c++) begin
      @(negedge clk);
      if (out_valid) begin
        checks++;
        if ({out_instr, out_err} !== w[got]) begin failures++; $display("FAIL full_order%0d got=%h exp=%h", got, {out_instr, out_err}, w[got]); end
        got++;
      end
      @(posedge clk); #1;
    end
    checks++; if (got !== 6) begin failures++; $display("FAIL full_total got=%0d exp=6", got); end
  endtask

  task automatic test_random();
    int bnd[14] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095, 4096,
                    -1048577, -1048576, 1048574, 1048575, 1048576};
    logic [32:0] e;
    logic acc, pp;
    reset = 0; in_valid = 0; out_ready = 0;
    @(posedge clk); #1;
    reset = 1; exp_count = 0; q.delete();
    for (int c = 0; c < 400; c++) begin
      in_valid = $urandom_range(0, 9) < 7;
      in_class = 3'($urandom_range(0, 7)); rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
      funct3 = 3'($urandom); funct7b5 = 1'($urandom);
      case ($urandom_range(0, 3))
        0: imm = 32'(bnd[$urandom_range(0, 13)]);
        1: imm = 32'(int'($urandom_range(0, 8191)) - 4096);
        2: imm = $urandom;
        default: imm = 32'(int'($urandom_range(0, 2097151)) - 1048576);
      endcase
      out_ready = $urandom_range(0, 9) < 6;
      @(negedge clk);
      acc = in_valid && (q.size() < 2 || out_ready);
      pp = q.size() > 0 && out_ready;
      checks++; if (out_valid !== (q.size() > 0)) begin failures++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, out_valid, q.size() > 0); end
      checks++; if (in_ready !== (q.size() < 2 || out_ready)) begin failures++; $display("FAIL rnd_in_ready c=%0d got=%b exp=%b", c, in_ready, q.size() < 2 || out_ready); end
      checks++; if (enc_count !== 16'(exp_count)) begin failures++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, enc_count, 16'(exp_count)); end
      if (pp) begin
        e = q.pop_front();
        checks++; if ({out_instr, out_err} !== e) begin failures++; $display("FAIL rnd_word c=%0d got=%h exp=%h", c, {out_instr, out_err}, e); end
      end
      if (acc) begin q.push_back(ref_enc(int'(in_class), int'(rd), int'(rs1), int'(rs2), int'(funct3), int'(funct7b5), imm)); exp_count++; end
      @(posedge clk); #1;
    end
    in_valid = 0; out_ready = 1;
    for (int c = 0; c < 5 && q.size() > 0; c++) begin
      @(negedge clk);
      e = q.pop_front();
      checks++; if (out_valid !== 1'b1 || {out_instr, out_err} !== e) begin failures++; $display("FAIL rnd_drain got=%b/%h exp=1/%h", out_valid, {out_instr, out_err}, e); end
      @(posedge clk); #1;
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rnd_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_midstream();
    out_ready = 0;
    drive(2, 7, 8, 9, 5, 0, 0);
    @(posedge clk); #1;
    drive(2, 9, 8, 7, 6, 1, 0);
    @(posedge clk); #1;
    in_valid = 0; exp_count += 2;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_buffered got=%b exp=1", out_valid); end
    checks++; if (enc_count !== 16'(exp_count)) begin failures++; $display("FAIL mid_count_before got=%0d exp=%0d", enc_count, exp_count); end
    reset = 0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
    checks++; if (enc_count !== 16'h0) begin failures++; $display("FAIL mid_count got=%0d exp=0", enc_count); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL mid_out_instr got=%h exp=0", out_instr); end
    reset = 1; exp_count = 0; out_ready = 1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_release_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_discard got=%b exp=0", out_valid); end
  endtask

  task automatic test_wrap();
    out_ready = 1;
    drive(0, 1, 1, 0, 0, 0, 4);
    repeat (65535) @(posedge clk);
    #1;
    checks++; if (enc_count !== 16'hFFFF) begin failures++; $display("FAIL wrap_max got=%h exp=ffff", enc_count); end
    @(posedge clk); #1;
    in_valid = 0;
    checks++; if (enc_count !== 16'h0) begin failures++; $display("FAIL wrap_zero got=%h exp=0000", enc_count); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_errors();
    test_backpressure();
    test_full_passthrough();
    test_random();
    test_reset_midstream();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of encoded-instruction counter.
REQ-002 SHALL have port clk  input  1  rising-edge clock, single clock domain.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  request accepted when in_valid&in_ready at clk edge.
REQ-006 SHALL have port in_class  input  3  instr_class_t: LW=0, SW=1, RTYPE=2, BEQ=3, IALU=4, JAL=5; 6,7 illegal.
REQ-007 SHALL have ports rd, rs1, rs2  input  5 each  register indices.
REQ-008 SHALL have port funct3  input  3  used for RTYPE/IALU only.
REQ-009 SHALL have port funct7b5  input  1  RTYPE funct7 bit 5 (sub/sra).
REQ-010 SHALL have port imm  input  32  signed byte-offset/immediate.
REQ-011 SHALL have port out_valid  output  1  encoded word present.
REQ-012 SHALL have port out_ready  input  1  consumer takes word when out_valid&out_ready.
REQ-013 SHALL have port out_instr  output  32  encoded RV32I word.
REQ-014 SHALL have port out_err  output  1  word is substituted NOP due to encode error.
REQ-015 SHALL have port enc_count  output  CNT_W  number of words accepted into buffer.

Function
REQ-016 SHALL encode opcodes: LW 0000011 f3=010; SW 0100011 f3=010; RTYPE 0110011; BEQ 1100011 f3=000; IALU 0010011; JAL 1101111.
REQ-017 SHALL place fields per RV32I I/S/R/B/J formats; RTYPE funct7 = {0,funct7b5,00000}; IALU uses imm[11:0] verbatim.
REQ-018 SHALL flag error when: class illegal; I/S imm outside [-2048,2047]; B imm outside [-4096,4094] or odd; J imm outside [-1048576,1048574] or odd.
REQ-019 SHALL, on error, store out_instr=32'h00000013 (NOP) with out_err=1; no other side effect differs.
REQ-020 SHALL buffer encoded words in a 2-entry FIFO; each entry holds {instr,err}.
REQ-021 SHALL assert in_ready = (occupancy<2) OR (occupancy==2 AND out_ready); push and pop in same cycle permitted at any occupancy.
REQ-022 SHALL present out_valid = (occupancy>0); out_instr/out_err from head entry, stable while out_valid&!out_ready.
REQ-023 SHALL give latency of one cycle: word accepted at edge N is visible on out_valid after edge N when FIFO was empty.
REQ-024 SHALL preserve strict in-order delivery; no drop, no duplication under any out_ready pattern.
REQ-025 SHALL increment enc_count by 1 per accepted request (including errors), wrapping from all-ones to 0.
REQ-026 SHALL ignore in_class/fields when in_valid=0; outputs change only at clk edges.

Reset
REQ-027 SHALL, while reset=0 at an edge, clear occupancy, pointers and enc_count; out_valid=0, out_instr=0, out_err=0, in_ready=0.
REQ-028 SHALL discard buffered words on reset mid-stream; in_ready=1 on first cycle after reset deasserts.

Structure
REQ-029 SHALL place instr_class_t, opcode constants and NOP constant in shared package riscv_pkg.
REQ-030 SHALL implement the 2-entry buffer as sub-module enc_fifo; encode/range-check logic combinational in instr_encoder.

Verification
REQ-031 SHALL check LW rd=5 rs1=2 imm=8 -> 32'h00812283, err=0; RTYPE rd=3 rs1=1 rs2=2 f3=0 f7b5=1 -> 32'h402081B3.
REQ-032 SHALL check SW rs1=2 rs2=6 imm=12 -> 32'h00612623; BEQ rs1=0 rs2=0 imm=8 -> 32'h00000463; JAL rd=1 imm=16 -> 32'h010000EF.
REQ-033 SHALL check BEQ imm=7 and IALU imm=2048 and in_class=6 -> 32'h00000013, err=1 each, enc_count advances by 3.
REQ-034 SHALL check out_ready=0 for 4 cycles with 3 requests offered -> 2 accepted, in_ready=0, third held; out_ready=1 drains in order.
REQ-035 SHALL check full FIFO with out_ready=1 and in_valid=1 -> simultaneous push/pop, occupancy stays 2, order kept.
REQ-036 SHALL check reset=0 with 2 words buffered -> out_valid=0, enc_count=0 next cycle; enc_count wrap 16'hFFFF -> 0.
